// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding.
package mult_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the shift-and-add multiplier.
interface shift_add_multiplier_if #(
  parameter int N = 8
) ();
  logic           req;
  logic           signed_mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           ack;
  logic [2*N-1:0] product;

  modport master (output req, signed_mode, a, b, input busy, ack, product);
  modport slave  (input req, signed_mode, a, b, output busy, ack, product);
endinterface

// File: rtl/mult_ctrl.sv
// Control FSM for the multiplier: sequences load, per-bit step, finish and the ack pulse.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic cnt_zero,
  input  logic mplr_zero,
  output logic busy,
  output logic ack,
  output logic load,
  output logic step,
  output logic finish
);
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    ack     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (req) begin
          load    = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // Once no multiplier bits remain, further shifting cannot change the sum.
        if (cnt_zero || ((EARLY_EXIT != 0) && mplr_zero)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier on operand magnitudes, sign applied to the final sum.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);
  localparam int CNT_W = $clog2(N + 1);

  // -2^(N-1) maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic is_signed);
    return (is_signed && v[N-1]) ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [2*N-1:0] product_q, product_d;

  logic busy, ack, load, step, finish;

  mult_ctrl #(.EARLY_EXIT(EARLY_EXIT)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req),
    .cnt_zero  (cnt_q == '0),
    .mplr_zero (mplr_q == '0),
    .busy      (busy),
    .ack       (ack),
    .load      (load),
    .step      (step),
    .finish    (finish)
  );

  always_comb begin
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load) begin
      mcand_d = {{N{1'b0}}, magnitude(bus.a, bus.signed_mode)};
      mplr_d  = magnitude(bus.b, bus.signed_mode);
      acc_d   = '0;
      cnt_d   = CNT_W'(N);
      neg_d   = bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
    end
    if (step) begin
      if (mplr_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
    if (finish) begin
      product_d = neg_q ? (~acc_q + {{(2*N-1){1'b0}}, 1'b1}) : acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.ack     = ack;
  assign bus.product = product_q;
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (N >= 2).
REQ-002 SHALL have parameter: EARLY_EXIT, 1, when 1 the computation terminates as soon as the remaining multiplier bits are zero.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with req.
REQ-007 SHALL have port: a  input  N  multiplicand, sampled with req.
REQ-008 SHALL have port: b  input  N  multiplier, sampled with req.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port: ack  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: product  output  2N  result register, held until overwritten by the next result.

Function
REQ-012 SHALL implement three states: IDLE, COMPUTE and DONE.
REQ-013 SHALL, on a clk edge in IDLE with req=1, load the magnitude |a| into the multiplicand register (2N bits, zero-extended) and |b| into the multiplier register (N bits), clear the accumulator, set the iteration count to N, latch neg = signed_mode & (a[N-1] ^ b[N-1]), and go to COMPUTE.
REQ-014 SHALL take magnitudes as the two's-complement negation of negative operands in signed mode and pass operands unchanged in unsigned mode; -2^(N-1) yields magnitude 2^(N-1) in N unsigned bits.
REQ-015 SHALL, on each COMPUTE edge where count != 0 and not (EARLY_EXIT=1 and multiplier == 0), add the multiplicand to the accumulator if multiplier[0]=1, shift the multiplicand left by 1, shift the multiplier right by 1, and decrement the count.
REQ-016 SHALL, on a COMPUTE edge where count == 0 or (EARLY_EXIT=1 and multiplier == 0), write product = neg ? -accumulator : accumulator (mod 2^2N) and go to DONE.
REQ-017 SHALL assert ack for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-018 SHALL, with EARLY_EXIT=0, assert ack starting N+1 edges after the accepting edge, for every operand pair.
REQ-019 SHALL, with EARLY_EXIT=1, assert ack k+1 edges after the accepting edge, where k = (index of the highest set bit of |b|) + 1, and k = 0 when b = 0.
REQ-020 SHALL ignore req in COMPUTE and DONE, and SHALL NOT change a held operand or result because of it; req still high on return to IDLE starts a new operation.
REQ-021 SHALL produce the exact 2N-bit product for every operand pair in both modes, including the -2^(N-1) x -2^(N-1) case.
REQ-022 SHALL ignore changes on a, b and signed_mode outside the accepting edge.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-COMPUTE, go to IDLE immediately with busy=0, ack=0 and product=0, and SHALL clear the accumulator, multiplicand, multiplier, count and neg registers to 0.
REQ-024 SHALL accept a req on the first clk edge after rst deasserts.

Structure
REQ-025 SHALL take the state encoding type and its constants from a shared package mult_pkg.
REQ-026 SHALL place the control FSM (state, busy, ack, and the load/add/shift/finish strobes) in a sub-module mult_ctrl, with the datapath registers in the top level.

Verification
REQ-027 N=8 unsigned, EARLY_EXIT=0: a=13, b=11 -> product=143, ack exactly 9 edges after accept, busy high throughout.
REQ-028 N=8 signed: a=-128, b=-128 -> product=16384; a=-7, b=5 -> product=0xFFDD (-35); a=127, b=-1 -> product=-127.
REQ-029 N=8, EARLY_EXIT=1: b=0 -> product=0 with ack 1 edge after accept; b=3, a=200 unsigned -> product=600 with ack 3 edges after accept.
REQ-030 req toggled during COMPUTE -> result unchanged and a single ack; req held high continuously -> back-to-back operations, each separated by one IDLE cycle.
REQ-031 rst pulse at the 4th COMPUTE cycle -> IDLE, product=0, no ack; the next req completes correctly.
REQ-032 A random regression of 10k operand pairs in both modes and both EARLY_EXIT values SHALL match a reference model and the latency formulas of REQ-018 and REQ-019.
